// File: rtl/ttl_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state codes and
// counter geometry (16-bit PC built from 4-bit slices).
package ttl_pkg;

    localparam int PC_W       = 16;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = PC_W / SLICE_W;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

endpackage

// File: rtl/cnt4_slice.sv
// One 4-bit synchronous up-counter slice with parallel load, count enable and
// active-low ripple carry out, modelled on a classic cascadable TTL counter.
module cnt4_slice
    import ttl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SLICE_W-1:0] rst_val_i,
    input  logic               load_i,
    input  logic [SLICE_W-1:0] din_i,
    input  logic               ent_i,
    output logic [SLICE_W-1:0] q_o,
    output logic               rco_n_o
);

    logic [SLICE_W-1:0] q_q;
    logic [SLICE_W-1:0] q_d;

    // Load wins over counting so a jump lands in every slice on the same edge.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = din_i;
        end else if (ent_i) begin
            q_d = q_q + SLICE_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= rst_val_i;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign rco_n_o = ~((&q_q) & ent_i);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/halt program-counter sequencer: a three-state FSM steering a
// 16-bit PC made of four cascaded cnt4_slice counters.
module pc_sequencer
    import ttl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ready,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] addr,
    output logic            fetch,
    output logic            rco_n,
    output logic [1:0]      state
);

    state_e state_q;
    state_e state_d;

    logic                  pc_load;
    logic                  ent0;
    logic [PC_W-1:0]       pc;
    logic [NUM_SLICES-1:0] ent;
    logic [NUM_SLICES-1:0] slice_rco_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = ready  ? ST_EXEC  : ST_FETCH;
            ST_EXEC:  state_d = halt   ? ST_HALT  : ST_FETCH;
            ST_HALT:  state_d = resume ? ST_FETCH : ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Reset gates the count enable so rco_n reads high while reset is held,
    // even if RESET_VECTOR is all ones and ready is asserted.
    assign pc_load = (state_q == ST_EXEC) && jump;
    assign ent0    = (state_q == ST_FETCH) && ready && !reset;

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        if (i == 0) begin : g_lsb
            assign ent[i] = ent0;
        end else begin : g_chain
            assign ent[i] = ~slice_rco_n[i-1];
        end

        cnt4_slice u_slice (
            .clk_i     (clock),
            .rst_i     (reset),
            .rst_val_i (RESET_VECTOR[i*SLICE_W +: SLICE_W]),
            .load_i    (pc_load),
            .din_i     (jump_addr[i*SLICE_W +: SLICE_W]),
            .ent_i     (ent[i]),
            .q_o       (pc[i*SLICE_W +: SLICE_W]),
            .rco_n_o   (slice_rco_n[i])
        );
    end

    assign addr  = pc;
    assign fetch = (state_q == ST_FETCH);
    assign rco_n = slice_rco_n[NUM_SLICES-1];
    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of single-cycle vectors followed by
// hand-written asynchronous reset sequences.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        ready;
    logic        jump;
    logic [15:0] jump_addr;
    logic        halt;
    logic        resume;
    logic [15:0] addr;
    logic        fetch;
    logic        rco_n;
    logic [1:0]  state;

    int checks;
    int errors;

    typedef struct {
        logic        rdy;
        logic        jmp;
        logic [15:0] ja;
        logic        hlt;
        logic        rsm;
        logic        exp_rco;
        logic [15:0] exp_addr;
        logic [1:0]  exp_st;
        logic        exp_fetch;
    } vec_t;

    vec_t vq[$];

    pc_sequencer #(.RESET_VECTOR(16'h0000)) dut (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .jump      (jump),
        .jump_addr (jump_addr),
        .halt      (halt),
        .resume    (resume),
        .addr      (addr),
        .fetch     (fetch),
        .rco_n     (rco_n),
        .state     (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic jmp, input logic [15:0] ja,
                       input logic hlt, input logic rsm, input logic exp_rco,
                       input logic [15:0] exp_addr, input logic [1:0] exp_st,
                       input logic exp_fetch);
        vec_t v;
        v.rdy = rdy; v.jmp = jmp; v.ja = ja; v.hlt = hlt; v.rsm = rsm;
        v.exp_rco = exp_rco; v.exp_addr = exp_addr; v.exp_st = exp_st;
        v.exp_fetch = exp_fetch;
        vq.push_back(v);
    endtask

    // Drive inputs, check the combinational carry before the edge, then
    // check registered outputs just after the edge.
    task automatic step(input string nm, input vec_t v);
        ready = v.rdy; jump = v.jmp; jump_addr = v.ja; halt = v.hlt; resume = v.rsm;
        #1;
        chk({nm, "_rco"}, {15'd0, rco_n}, {15'd0, v.exp_rco});
        @(posedge clock);
        #1;
        chk({nm, "_addr"},  addr, v.exp_addr);
        chk({nm, "_state"}, {14'd0, state}, {14'd0, v.exp_st});
        chk({nm, "_fetch"}, {15'd0, fetch}, {15'd0, v.exp_fetch});
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_addr"},  addr, 16'h0000);
        chk({nm, "_state"}, {14'd0, state}, 16'h0000);
        chk({nm, "_fetch"}, {15'd0, fetch}, 16'h0001);
        chk({nm, "_rco"},   {15'd0, rco_n}, 16'h0001);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        //   rdy  jmp  ja       hlt  rsm  rco  addr     st     fetch
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0001,2'b01,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0001,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0002,2'b01,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0002,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0003,2'b01,1'b0);
        add(1'b1,1'b1,16'h0005,1'b0,1'b0,1'b1,16'h0005,2'b00,1'b1);
        add(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0005,2'b00,1'b1);
        add(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0005,2'b00,1'b1);
        add(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0005,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0006,2'b01,1'b0);
        add(1'b0,1'b1,16'h00FF,1'b0,1'b0,1'b1,16'h00FF,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0100,2'b01,1'b0);
        add(1'b0,1'b1,16'hFFFF,1'b0,1'b0,1'b1,16'hFFFF,2'b00,1'b1);
        add(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'hFFFF,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000,2'b01,1'b0);
        add(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0000,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0001,2'b01,1'b0);
        add(1'b0,1'b1,16'hABCD,1'b1,1'b0,1'b1,16'hABCD,2'b10,1'b0);
        add(1'b1,1'b1,16'h1111,1'b1,1'b0,1'b1,16'hABCD,2'b10,1'b0);
        add(1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'hABCD,2'b10,1'b0);
        add(1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,16'hABCD,2'b00,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'hABCE,2'b01,1'b0);
        add(1'b0,1'b0,16'h0000,1'b1,1'b0,1'b1,16'hABCE,2'b10,1'b0);
        add(1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,16'hABCE,2'b00,1'b1);

        reset = 1'b1; ready = 1'b1; jump = 1'b0; jump_addr = 16'h0000;
        halt = 1'b0; resume = 1'b0;
        #12;
        chk_reset_state("reset_hold");
        @(negedge clock);
        reset = 1'b0;
        ready = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("v%0d", i), vq[i]);
        end

        // Asynchronous reset while halted at 1234
        v = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'hABCF,2'b01,1'b0};
        step("h_exec", v);
        v = '{1'b0,1'b1,16'h1234,1'b1,1'b0,1'b1,16'h1234,2'b10,1'b0};
        step("h_halt", v);
        #2 reset = 1'b1;
        #1 chk_reset_state("rst_in_halt");
        @(negedge clock);
        reset = 1'b0;
        v = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0001,2'b01,1'b0};
        step("post_halt_rst", v);

        // Asynchronous reset during a stalled fetch
        v = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0001,2'b00,1'b1};
        step("f_enter", v);
        v = '{1'b1,1'b1,16'h0000,1'b0,1'b0,1'b1,16'h0002,2'b01,1'b0};
        step("f_adv", v);
        v = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0002,2'b00,1'b1};
        step("f_wait", v);
        #2 reset = 1'b1;
        #1 chk_reset_state("rst_in_fetch");
        @(negedge clock);
        reset = 1'b0;
        v = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0000,2'b00,1'b1};
        step("post_fetch_rst", v);
        v = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h0001,2'b01,1'b0};
        step("post_fetch_adv", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000, meaning: PC value loaded by reset.
REQ-002 Port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port ready  input  1  memory acknowledges the current fetch this cycle.
REQ-005 Port jump  input  1  load jump_addr into PC; sampled in EXEC only.
REQ-006 Port jump_addr  input  16  branch target.
REQ-007 Port halt  input  1  enter HALT; sampled in EXEC only.
REQ-008 Port resume  input  1  leave HALT; sampled in HALT only.
REQ-009 Port addr  output  16  current PC, driven to memory.
REQ-010 Port fetch  output  1  high while a fetch is outstanding (state FETCH).
REQ-011 Port rco_n  output  1  active-low carry out of the 16-bit counter chain.
REQ-012 Port state  output  2  current FSM state encoding, for debug and bench.

Function
REQ-013 The FSM SHALL have exactly three states: FETCH=2'b00, EXEC=2'b01, HALT=2'b10; 2'b11 is illegal and SHALL go to FETCH on the next edge.
REQ-014 FETCH: fetch=1; if ready, PC increments by 1 and next state is EXEC; if not ready, PC holds and state stays FETCH (unbounded wait states).
REQ-015 EXEC: fetch=0; PC holds unless jump=1; next state is FETCH.
REQ-016 EXEC with jump=1: PC SHALL equal jump_addr on the following edge.
REQ-017 EXEC with halt=1: next state is HALT; halt has priority over the state transition, but a simultaneous jump SHALL still load PC.
REQ-018 HALT: fetch=0; PC holds; resume=1 moves to FETCH on the next edge; jump, ready and halt are ignored.
REQ-019 The PC SHALL be built as four cascaded 4-bit slices; each slice's count enable (ent) SHALL be the inverted rco_n of the slice below; slice 0 ent = (state==FETCH && ready).
REQ-020 rco_n SHALL be combinational: low iff PC==16'hFFFF and slice-0 ent is high; otherwise high.
REQ-021 Increment from 16'hFFFF SHALL wrap to 16'h0000 with no other side effect.
REQ-022 Load (jump) SHALL override counting in every slice; all four slices load in the same edge.
REQ-023 addr SHALL be the registered PC with zero combinational path from any input.

Reset
REQ-024 reset=1 SHALL asynchronously force PC=RESET_VECTOR, state=FETCH, fetch=1, and rco_n=1, regardless of ready.
REQ-025 Reset asserted mid-fetch or mid-HALT SHALL abandon the operation; the first fetch after release SHALL be from RESET_VECTOR.
REQ-026 Deasserting reset SHALL take effect at the next rising clock edge.

Structure
REQ-027 State encodings, PC width (16) and slice width (4) SHALL live in shared package ttl_pkg.
REQ-028 One sub-module, cnt4_slice, SHALL implement one 4-bit synchronous up counter with async active-high reset, reset value input, parallel load, ent, and rco_n (low when q==4'hF and ent=1).
REQ-029 pc_sequencer SHALL instantiate four cnt4_slice instances plus the FSM; no other sub-modules.

Verification
REQ-030 Reset, then ready=1 continuously for 4 cycles -> addr 0000, 0001 (EXEC), 0001 (FETCH), 0002; state alternates 00/01.
REQ-031 FETCH at addr 0005 with ready=0 for 3 cycles then 1 -> addr stays 0005 and fetch=1 for 3 cycles, then 0006 and state EXEC.
REQ-032 PC=00FF in FETCH, ready=1 -> rco_n stays 1; next addr 0100 (carry ripples through slices 0-1).
REQ-033 PC=FFFF in FETCH, ready=1 -> rco_n=0 that cycle; next addr 0000, rco_n=1.
REQ-034 EXEC with jump=1, jump_addr=ABCD, halt=1 -> addr ABCD, state HALT; resume=0 for 2 cycles holds; resume=1 -> FETCH at ABCD.
REQ-035 reset pulsed asynchronously between edges while in HALT at 1234 -> addr immediately RESET_VECTOR, state FETCH, fetch=1 before the next edge.
